// File: rtl/quad_steer_multi.sv
// Multi-channel left/right to quadrature (Gray) steering encoder with 2-flop input
// synchronisers and hold-time acceleration. Define QUAD_STEER_POS_EN to add per-channel position outputs.
module quad_steer_multi #(
  parameter int CHANNELS   = 2,
  parameter int DIV_W      = 16,
  parameter int ACCEL_HOLD = 8,
  parameter int ACCEL_MAX  = 2
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   right,
`ifdef QUAD_STEER_POS_EN
  output logic [2*CHANNELS-1:0] steer,
  output logic [8*CHANNELS-1:0] pos
`else
  output logic [2*CHANNELS-1:0] steer
`endif
);

  localparam int HOLD_W = (ACCEL_HOLD > 1) ? $clog2(ACCEL_HOLD) : 1;
  localparam int LVL_W  = (ACCEL_MAX > 0) ? $clog2(ACCEL_MAX + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_HOLD - 1);
  localparam logic [LVL_W-1:0]  LVL_TOP   = LVL_W'(ACCEL_MAX);

  typedef enum logic [1:0] {DIR_IDLE = 2'd0, DIR_CW = 2'd1, DIR_CCW = 2'd2} dir_t;

  // Gray code is walked by converting to a binary index, stepping, and converting back.
  function automatic logic [1:0] gray_step(input logic [1:0] g, input logic cw);
    logic [1:0] idx;
    idx = {g[1], g[1] ^ g[0]};
    idx = cw ? idx + 2'd1 : idx - 2'd1;
    return {idx[1], idx[1] ^ idx[0]};
  endfunction

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [1:0]        l_sync, r_sync;
      dir_t              dir, dir_reg;
      logic [DIV_W-1:0]  cnt_reg, cnt_next, cur_cnt, shifted, eff_m1;
      logic [HOLD_W-1:0] hold_reg, hold_next, cur_hold;
      logic [LVL_W-1:0]  level_reg, level_next, cur_level;
      logic [1:0]        phase_reg;
      logic              step;

      always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
          l_sync    <= '0;
          r_sync    <= '0;
          dir_reg   <= DIR_IDLE;
          cnt_reg   <= '0;
          hold_reg  <= '0;
          level_reg <= '0;
          phase_reg <= '0;
        end else begin
          l_sync    <= {l_sync[0], left[gi]};
          r_sync    <= {r_sync[0], right[gi]};
          dir_reg   <= dir;
          cnt_reg   <= cnt_next;
          hold_reg  <= hold_next;
          level_reg <= level_next;
          if (step) phase_reg <= gray_step(phase_reg, dir == DIR_CW);
        end
      end

      // A direction that differs from last cycle's starts fresh, so a CW<->CCW flip
      // counts from zero at base rate exactly like a start from idle.
      always_comb begin
        dir = DIR_IDLE;
        if (r_sync[1] && !l_sync[1])      dir = DIR_CW;
        else if (l_sync[1] && !r_sync[1]) dir = DIR_CCW;
        cur_cnt   = (dir == dir_reg) ? cnt_reg   : '0;
        cur_hold  = (dir == dir_reg) ? hold_reg  : '0;
        cur_level = (dir == dir_reg) ? level_reg : '0;
        shifted   = clkdiv >> cur_level;
        eff_m1    = (shifted == '0) ? '0 : shifted - DIV_W'(1);
        cnt_next   = cur_cnt;
        hold_next  = cur_hold;
        level_next = cur_level;
        step       = 1'b0;
        if (dir == DIR_IDLE || clkdiv == '0) begin
          cnt_next   = '0;
          hold_next  = '0;
          level_next = '0;
        end else if (cur_cnt == eff_m1) begin
          step     = 1'b1;
          cnt_next = '0;
          if (cur_hold == HOLD_LAST && cur_level < LVL_TOP) begin
            level_next = cur_level + LVL_W'(1);
            hold_next  = '0;
          end else if (cur_hold != HOLD_LAST) begin
            hold_next = cur_hold + HOLD_W'(1);
          end
        end else if (cur_cnt > eff_m1) begin
          cnt_next = '0;
        end else begin
          cnt_next = cur_cnt + DIV_W'(1);
        end
      end

      assign steer[2*gi +: 2] = phase_reg;

`ifdef QUAD_STEER_POS_EN
      logic [7:0] pos_reg;
      always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)  pos_reg <= '0;
        else if (step) pos_reg <= (dir == DIR_CW) ? pos_reg + 8'd1 : pos_reg - 8'd1;
      end
      assign pos[8*gi +: 8] = pos_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_quad_steer_multi.sv
// Scoreboard bench for quad_steer_multi: a timing/step reference model queues expected
// steps per channel and a monitor compares each observed phase change against them.
module tb_quad_steer_multi;
  localparam int CH = 2;
  localparam int DW = 16;
  localparam int AH = 4;
  localparam int AM = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] clkdiv = 16'd8;
  logic [CH-1:0] left = '0;
  logic [CH-1:0] right = '0;
  logic [2*CH-1:0] steer;
`ifdef QUAD_STEER_POS_EN
  logic [8*CH-1:0] pos;
`endif

  quad_steer_multi #(.CHANNELS(CH), .DIV_W(DW), .ACCEL_HOLD(AH), .ACCEL_MAX(AM)) dut (
    .CLK(clk),
    .Reset_n(rst_n),
    .clkdiv(clkdiv),
    .left(left),
    .right(right),
`ifdef QUAD_STEER_POS_EN
    .pos(pos),
`endif
    .steer(steer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] ph;
    logic [7:0] ps;
  } exp_t;

  exp_t q[CH][$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [1:0] gray(input int i);
    case (i)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Reference model: inputs seen two edges late; a step fires once `per` active cycles
  // have elapsed; rate level = completed steps / AH, capped at AM.
  initial begin
    int m_prev[CH], m_el[CH], m_steps[CH], m_idx[CH];
    logic [7:0] m_pos[CH];
    logic [CH-1:0] l1, l2, r1, r2;
    int d, per, lvl;
    exp_t e;
    l1 = '0; l2 = '0; r1 = '0; r2 = '0;
    for (int c = 0; c < CH; c++) begin
      m_prev[c] = 0; m_el[c] = 0; m_steps[c] = 0; m_idx[c] = 0; m_pos[c] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        l1 = '0; l2 = '0; r1 = '0; r2 = '0;
        for (int c = 0; c < CH; c++) begin
          m_prev[c] = 0; m_el[c] = 0; m_steps[c] = 0; m_idx[c] = 0; m_pos[c] = '0;
        end
      end else begin
        for (int c = 0; c < CH; c++) begin
          d = (r2[c] && !l2[c]) ? 1 : ((l2[c] && !r2[c]) ? -1 : 0);
          if (d != m_prev[c]) begin
            m_el[c] = 0;
            m_steps[c] = 0;
          end
          m_prev[c] = d;
          if (d == 0 || clkdiv == 0) begin
            m_el[c] = 0;
            m_steps[c] = 0;
          end else begin
            lvl = m_steps[c] / AH;
            if (lvl > AM) lvl = AM;
            per = int'(clkdiv) >> lvl;
            if (per < 1) per = 1;
            if (m_el[c] >= per) begin
              m_el[c] = 0;
            end else begin
              m_el[c]++;
              if (m_el[c] == per) begin
                m_el[c] = 0;
                m_steps[c]++;
                m_idx[c] = (m_idx[c] + d + 4) % 4;
                m_pos[c] = m_pos[c] + 8'(d);
                e.cyc = cyc;
                e.ph = gray(m_idx[c]);
                e.ps = m_pos[c];
                q[c].push_back(e);
              end
            end
          end
        end
        l2 = l1; l1 = left;
        r2 = r1; r1 = right;
      end
    end
  end

  // Monitor: every phase change must match the head of that channel's queue.
  initial begin
    logic [1:0] last[CH];
    logic [1:0] cur;
    exp_t e;
    for (int c = 0; c < CH; c++) last[c] = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        cur = steer[2*c +: 2];
        if (!rst_n) begin
          checks++;
          if (cur !== 2'b00) begin
            failures++;
            $display("FAIL reset_steer ch=%0d cyc=%0d got=%b want=00", c, cyc, cur);
          end
          last[c] = 2'b00;
          q[c].delete();
        end else if (cur !== last[c]) begin
          checks++;
          if (q[c].size() == 0) begin
            failures++;
            $display("FAIL unexpected_step ch=%0d cyc=%0d got=%b no step expected", c, cyc, cur);
          end else begin
            e = q[c].pop_front();
            if (e.ph !== cur || e.cyc != cyc) begin
              failures++;
              $display("FAIL step ch=%0d got ph=%b cyc=%0d want ph=%b cyc=%0d", c, cur, cyc, e.ph, e.cyc);
            end else begin
              $display("step ch=%0d cyc=%0d ph=%b", c, cyc, cur);
            end
`ifdef QUAD_STEER_POS_EN
            checks++;
            if (pos[8*c +: 8] !== e.ps) begin
              failures++;
              $display("FAIL pos ch=%0d cyc=%0d got=%0d want=%0d", c, cyc,
                       $signed(pos[8*c +: 8]), $signed(e.ps));
            end
`endif
          end
          last[c] = cur;
        end else if (q[c].size() > 0 && q[c][0].cyc <= cyc) begin
          checks++;
          failures++;
          e = q[c].pop_front();
          $display("FAIL missed_step ch=%0d cyc=%0d got=%b want ph=%b at cyc=%0d", c, cyc, cur, e.ph, e.cyc);
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int c0;
    int seg;
    bit seen;
    int divs[7];
    divs = '{0, 1, 2, 3, 5, 8, 13};

    // Reset held with inputs active: steer must stay 0 (checked by monitor).
    @(negedge clk);
    rst_n = 1'b0;
    left = 2'b10;
    right = 2'b01;
    idle_cycles(6);
    left = '0;
    right = '0;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(3);

    // First step latency: 2 sync cycles + clkdiv.
    right[0] = 1'b1;
    c0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (steer[1:0] != 2'b00) seen = 1'b1;
    end
    checks++;
    if (!seen || (cyc - c0) != 10 || steer !== 4'b0001) begin
      failures++;
      $display("FAIL first_step got latency=%0d steer=%b want latency=10 steer=0001", cyc - c0, steer);
    end
    @(negedge clk);

    // Hold CW through acceleration, then flip to CCW.
    idle_cycles(80);
    right[0] = 1'b0;
    left[0] = 1'b1;
    idle_cycles(40);

    // Both pressed on ch1, then release right -> CCW at base rate.
    left[1] = 1'b1;
    right[1] = 1'b1;
    idle_cycles(100);
    right[1] = 1'b0;
    idle_cycles(30);

    // clkdiv=0 freezes stepping, restore resumes.
    clkdiv = 16'd0;
    idle_cycles(20);
    clkdiv = 16'd8;
    idle_cycles(30);

    // Asynchronous reset mid-run while ch0 is accelerating.
    left = '0;
    right = 2'b01;
    idle_cycles(45);
    rst_n = 1'b0;
    #1;
    checks++;
    if (steer !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got=%b want=0000", steer);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(40);

    // Randomised segments, including occasional clkdiv changes mid-count.
    for (int s = 0; s < 60; s++) begin
      left = CH'($urandom);
      right = CH'($urandom);
      if ($urandom_range(0, 4) == 0) clkdiv = DW'(divs[$urandom_range(0, 6)]);
      seg = $urandom_range(1, 50);
      idle_cycles(seg);
    end

    left = '0;
    right = '0;
    clkdiv = 16'd8;
    idle_cycles(20);
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (q[c].size() != 0) begin
        failures++;
        $display("FAIL drain ch=%0d got pending=%0d want 0", c, q[c].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_steer_multi.md
Name: quad_steer_multi

Overview:
- Parametrised successor to the single-channel joystick-to-quadrature steering encoder.
- Converts per-channel digital left/right inputs into 2-bit quadrature (Gray) phase outputs. These drive the steering encoder inputs of Sprint-family game cores (Sprint 1 with one player, Sprint 2 with two).
- Adds N channels, input synchronisation, and hold-time acceleration; the previous block had a fixed single-rate stepper.
- Sits in the emu top level between the joystick/keyboard merge logic and the core's SteerA/SteerB inputs.

Parameters:
- CHANNELS, 2, number of independent steering channels (1..4).
- DIV_W, 16, width of the clkdiv step-period input.
- ACCEL_HOLD, 8, consecutive same-direction steps before the rate level increments.
- ACCEL_MAX, 2, maximum rate level; period is shifted right by the level, so up to 4x faster.

Ports:
- CLK, in, 1: system clock (clk_sys, 12 MHz).
- Reset_n, in, 1: asynchronous active-low reset.
- clkdiv, in, DIV_W: base step period in CLK cycles, shared by all channels; quasi-static.
- left, in, CHANNELS: per-channel left request, active high, asynchronous.
- right, in, CHANNELS: per-channel right request, active high, asynchronous.
- steer, out, 2*CHANNELS: per-channel quadrature phase. steer[2c+1] = A and steer[2c] = B of channel c.

Behaviour:
- Reset (Reset_n=0, asynchronous) clears the following; they stay cleared until release:
  - all synchroniser flops;
  - prescaler counters;
  - rate levels;
  - step-hold counters;
  - phase registers, so steer = all 0.
- Synchronisation: left and right each pass through a 2-flop synchroniser per channel, giving 2 cycles of input latency. All following logic uses the synced values sl/sr.
- Per-channel direction decode:
  - IDLE when sl == sr (neither input or both inputs active);
  - CW when sr=1 and sl=0;
  - CCW when sl=1 and sr=0.
- Period:
  - eff = clkdiv >> level, clamped to a minimum of 1.
  - clkdiv = 0 disables stepping on all channels; counters are held at 0 and phases are held.
- Prescaler: in CW or CCW the counter increments each cycle. When cnt == eff-1:
  - cnt returns to 0;
  - the phase advances one step; the registered steer output updates on the same edge.
- First step occurs eff cycles after sl/sr become valid, which is 2+clkdiv cycles after the raw input edge.
- Phase sequence:
  - CW: 00→01→11→10→00.
  - CCW: reverse order.
  - Wraps freely; each step changes exactly one bit.
- Acceleration:
  - Each step in an unchanged direction increments hold.
  - When hold reaches ACCEL_HOLD-1 on a step and level < ACCEL_MAX: level increments and hold returns to 0.
  - At ACCEL_MAX, hold saturates and no longer wraps.
- Leaving a direction resets cnt, hold and level to 0 on the next cycle. This covers a move to IDLE and any direct CW↔CCW flip. Phase is retained.
- Simultaneous left+right is treated as IDLE: no step, and acceleration is reset.
- A change of clkdiv mid-count takes effect at the next comparison. If cnt already exceeds the new eff-1, cnt is forced to 0 without stepping.
- Channels are fully independent; there is no shared state except clkdiv.

Optional Feature:
- Macro QUAD_STEER_POS_EN.
- When defined:
  - adds output port pos, out, 8*CHANNELS, one signed 8-bit position per channel;
  - pos increments on each CW step and decrements on each CCW step, wrapping two's-complement (127+1 → -128);
  - reset value is 0; updates on the same edge as steer.
- When undefined, the port and its counters are absent; steer behaviour is identical either way.

Test Plan:
- Common bench settings: CHANNELS=2, clkdiv=8, ACCEL_HOLD=4, ACCEL_MAX=2.
- Reset: assert Reset_n=0 with inputs active → steer=4'b0000 held. Release, then right[0]=1 → first ch0 step (00→01) exactly 10 cycles after the right edge; ch1 stays 00.
- CW sequence: hold right[0] → ch0 steps 01,11,10,00 at 8-cycle intervals for the first 4 steps. Then 4-cycle intervals for 4 steps, then 2-cycle intervals sustained.
- Direction flip: after reaching level 2, switch to left[0] → the next step comes 8 cycles after sl is valid and reverses the sequence (e.g. 10→11). Level returns to 0.
- Both pressed: left[1]=right[1]=1 for 100 cycles → ch1 phase unchanged. Release right[1] → CCW step after 10 cycles at base rate.
- clkdiv=0 while stepping → no further steps, and cnt reads 0. Restore clkdiv=8 → stepping resumes 8 cycles later.
- Async reset mid-step (Reset_n low for 1 cycle at cnt=5, level 1) → steer=0 immediately. After release, stepping restarts at base period. With QUAD_STEER_POS_EN: pos=0 after the reset, and 130 CW steps from 0 yield pos=-126.
